// File: rtl/pifo_ctrl_if.sv
// pifo_ctrl_if: groups the enqueue stream, the dequeue stream and the PIFO
// insert/remove port of the PIFO client controller.
//   enq_*  : upstream valid/ready stream (rank + metadata)
//   deq_*  : downstream registered valid/ready stream
//   pifo_* : PIFO insert strobe/data, remove strobe, head outputs, busy/full
// Modports: master = the controller, slave = its environment (source, sink, PIFO).
interface pifo_ctrl_if #(
  parameter int RANK_WIDTH = 10,
  parameter int META_WIDTH = 20
);
  logic                  enq_valid;
  logic                  enq_ready;
  logic [RANK_WIDTH-1:0] enq_rank;
  logic [META_WIDTH-1:0] enq_meta;

  logic                  deq_valid;
  logic                  deq_ready;
  logic [RANK_WIDTH-1:0] deq_rank;
  logic [META_WIDTH-1:0] deq_meta;

  logic                  pifo_insert;
  logic [RANK_WIDTH-1:0] pifo_rank_in;
  logic [META_WIDTH-1:0] pifo_meta_in;
  logic                  pifo_remove;
  logic [RANK_WIDTH-1:0] pifo_rank_out;
  logic [META_WIDTH-1:0] pifo_meta_out;
  logic                  pifo_valid_out;
  logic                  pifo_busy;
  logic                  pifo_full;

  modport master (
    input  enq_valid, enq_rank, enq_meta,
    output enq_ready,
    output deq_valid, deq_rank, deq_meta,
    input  deq_ready,
    output pifo_insert, pifo_rank_in, pifo_meta_in, pifo_remove,
    input  pifo_rank_out, pifo_meta_out, pifo_valid_out, pifo_busy, pifo_full
  );

  modport slave (
    output enq_valid, enq_rank, enq_meta,
    input  enq_ready,
    input  deq_valid, deq_rank, deq_meta,
    output deq_ready,
    input  pifo_insert, pifo_rank_in, pifo_meta_in, pifo_remove,
    output pifo_rank_out, pifo_meta_out, pifo_valid_out, pifo_busy, pifo_full
  );
endinterface

// File: rtl/pifo_ctrl.sv
// pifo_ctrl: client-side controller for the PIFO scheduler.
// Buffers the upstream enqueue stream in a small FIFO, writes entries into the
// PIFO when it is neither busy nor full, issues removes to feed a registered
// dequeue output, tracks PIFO occupancy and implements a flush that discards
// every queued entry (FIFO, output register and PIFO contents).
// Ports:
//   clk, rst    : clock, synchronous active-high reset (the PIFO shares rst)
//   bus         : pifo_ctrl_if master (enq_*, deq_*, pifo_* signals)
//   flush       : level request to discard all entries
//   flush_done  : one-cycle pulse when a flush completes
//   occupancy   : entries currently held in the PIFO
//   flush_drops : saturating count of entries discarded by flushes
module pifo_ctrl #(
  parameter int RANK_WIDTH    = 10,
  parameter int META_WIDTH    = 20,
  parameter int L2_FIFO_DEPTH = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pifo_ctrl_if.master          bus,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic [CNT_WIDTH-1:0] flush_drops
);

  localparam int unsigned DEPTH = 1 << L2_FIFO_DEPTH;

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;
  state_t state;

  logic [RANK_WIDTH-1:0]    fifo_rank [DEPTH];
  logic [META_WIDTH-1:0]    fifo_meta [DEPTH];
  logic [L2_FIFO_DEPTH-1:0] wr_ptr;
  logic [L2_FIFO_DEPTH-1:0] rd_ptr;
  logic [L2_FIFO_DEPTH:0]   fifo_count;
  logic [L2_FIFO_DEPTH:0]   count_next;
  logic                     fifo_full;
  logic                     fifo_empty;

  logic                  deq_valid_q;
  logic [RANK_WIDTH-1:0] deq_rank_q;
  logic [META_WIDTH-1:0] deq_meta_q;

  logic                   push;
  logic                   pop;
  logic                   remove;
  logic                   deq_keep;
  logic [CNT_WIDTH-1:0]   occ_next;
  logic [L2_FIFO_DEPTH+1:0] drop_add;
  logic [CNT_WIDTH:0]     drop_sum;
  logic [CNT_WIDTH-1:0]   drops_next;

  assign fifo_empty = (fifo_count == '0);

  always_comb begin
    push = bus.enq_valid && (state == RUN) && !fifo_full;
    pop  = (state == RUN) && !fifo_empty && !bus.pifo_busy && !bus.pifo_full;

    unique case (state)
      RUN:     remove = bus.pifo_valid_out && (!deq_valid_q || bus.deq_ready);
      FLUSH:   remove = bus.pifo_valid_out;
      default: remove = 1'b0;
    endcase

    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + (L2_FIFO_DEPTH+1)'(1);
    else if (pop && !push) count_next = fifo_count - (L2_FIFO_DEPTH+1)'(1);

    // Output entry still held after this edge; it is lost if a flush starts now.
    deq_keep = remove || (deq_valid_q && !bus.deq_ready);

    occ_next = occupancy;
    if (pop && !remove && occupancy != '1)      occ_next = occupancy + CNT_WIDTH'(1);
    else if (remove && !pop && occupancy != '0) occ_next = occupancy - CNT_WIDTH'(1);

    // Flush entry drops the FIFO contents (after this cycle's push/pop) plus
    // any held output entry; inside FLUSH every remove is a drop.
    drop_add = '0;
    if (state == RUN && flush)
      drop_add = {1'b0, count_next} + {{(L2_FIFO_DEPTH+1){1'b0}}, deq_keep};
    else if (state == FLUSH)
      drop_add = {{(L2_FIFO_DEPTH+1){1'b0}}, remove};
    drop_sum   = {1'b0, flush_drops} + (CNT_WIDTH+1)'(drop_add);
    drops_next = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
  end

  assign bus.enq_ready    = (state == RUN) && !fifo_full;
  assign bus.pifo_insert  = pop;
  assign bus.pifo_rank_in = pop ? fifo_rank[rd_ptr] : '0;
  assign bus.pifo_meta_in = pop ? fifo_meta[rd_ptr] : '0;
  assign bus.pifo_remove  = remove;
  assign bus.deq_valid    = deq_valid_q;
  assign bus.deq_rank     = deq_rank_q;
  assign bus.deq_meta     = deq_meta_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rank[wr_ptr] <= bus.enq_rank;
      fifo_meta[wr_ptr] <= bus.enq_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state == RUN && flush)) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + L2_FIFO_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + L2_FIFO_DEPTH'(1);
      fifo_count <= count_next;
      // Count never exceeds DEPTH, so its MSB alone marks full.
      fifo_full  <= count_next[L2_FIFO_DEPTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      deq_valid_q <= 1'b0;
      deq_rank_q  <= '0;
      deq_meta_q  <= '0;
      occupancy   <= '0;
      flush_drops <= '0;
      flush_done  <= 1'b0;
    end else begin
      flush_done  <= 1'b0;
      occupancy   <= occ_next;
      flush_drops <= drops_next;
      unique case (state)
        INIT: begin
          if (!bus.pifo_busy) state <= RUN;
        end
        RUN: begin
          if (remove) begin
            deq_valid_q <= 1'b1;
            deq_rank_q  <= bus.pifo_rank_out;
            deq_meta_q  <= bus.pifo_meta_out;
          end else if (bus.deq_ready) begin
            deq_valid_q <= 1'b0;
          end
          if (flush) begin
            deq_valid_q <= 1'b0;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          if (occupancy == '0 && !bus.pifo_valid_out) begin
            state      <= RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  occ_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(remove && !pop && occupancy == '0));
  occ_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !remove && occupancy == '1));

endmodule

// File: tb/tb_pifo_ctrl.sv
// tb_pifo_ctrl: directed bench for pifo_ctrl with a PIFO model, a reference
// model of the controller checked every cycle, and literal expectations.
module tb_pifo_ctrl;
  localparam int RW = 10;
  localparam int MW = 20;
  localparam int CW = 16;
  localparam int L2 = 2;
  localparam int DEPTH = 4;
  localparam int CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          flush_done;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] flush_drops;

  pifo_ctrl_if #(.RANK_WIDTH(RW), .META_WIDTH(MW)) bus ();

  pifo_ctrl #(.RANK_WIDTH(RW), .META_WIDTH(MW), .L2_FIFO_DEPTH(L2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .flush_done(flush_done), .occupancy(occupancy), .flush_drops(flush_drops)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [RW-1:0] r;
    logic [MW-1:0] m;
  } ent_t;

  // PIFO model: sorted by rank, ties keep arrival order; head visible next cycle.
  ent_t pq[$];
  ent_t pe;
  int   pk;
  always @(posedge clk) begin
    if (rst) pq.delete();
    else begin
      if (bus.pifo_remove && pq.size() > 0) void'(pq.pop_front());
      if (bus.pifo_insert) begin
        pe.r = bus.pifo_rank_in;
        pe.m = bus.pifo_meta_in;
        pk = 0;
        while (pk < pq.size() && pq[pk].r <= pe.r) pk++;
        pq.insert(pk, pe);
      end
    end
    bus.pifo_valid_out <= (pq.size() > 0);
    bus.pifo_rank_out  <= (pq.size() > 0) ? pq[0].r : '0;
    bus.pifo_meta_out  <= (pq.size() > 0) ? pq[0].m : '0;
  end

  // Reference model of the controller. phase: 0 waiting, 1 running, 2 flushing.
  int            m_phase;
  ent_t          m_fifo[$];
  ent_t          me;
  logic          m_dv;
  logic [RW-1:0] m_dr;
  logic [MW-1:0] m_dm;
  int            m_occ;
  int            m_drops;
  logic          m_done;
  bit            m_started = 0;

  function automatic logic f_ready();
    return m_phase == 1 && m_fifo.size() < DEPTH;
  endfunction
  function automatic logic f_ins();
    return m_phase == 1 && m_fifo.size() > 0 && !bus.pifo_busy && !bus.pifo_full;
  endfunction
  function automatic logic f_rem();
    if (m_phase == 1) return bus.pifo_valid_out && (!m_dv || bus.deq_ready);
    if (m_phase == 2) return bus.pifo_valid_out;
    return 1'b0;
  endfunction
  function automatic int sat_add(input int a, input int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  always @(posedge clk) begin
    logic ins, rem, push;
    int   occ_before;
    if (rst) begin
      m_phase = 0; m_fifo.delete(); m_dv = 0; m_dr = '0; m_dm = '0;
      m_occ = 0; m_drops = 0; m_done = 0; m_started = 1;
    end else if (m_started) begin
      ins = f_ins(); rem = f_rem(); push = bus.enq_valid && f_ready();
      occ_before = m_occ;
      m_done = 0;
      if (ins && !rem && m_occ < CMAX) m_occ++;
      else if (rem && !ins && m_occ > 0) m_occ--;
      case (m_phase)
        0: if (!bus.pifo_busy) m_phase = 1;
        1: begin
          if (ins) void'(m_fifo.pop_front());
          if (push) begin
            me.r = bus.enq_rank; me.m = bus.enq_meta;
            m_fifo.push_back(me);
          end
          if (rem) begin
            m_dv = 1; m_dr = bus.pifo_rank_out; m_dm = bus.pifo_meta_out;
          end else if (bus.deq_ready) m_dv = 0;
          if (flush) begin
            m_drops = sat_add(m_drops, m_fifo.size() + (m_dv ? 1 : 0));
            m_fifo.delete();
            m_dv = 0;
            m_phase = 2;
          end
        end
        default: begin
          if (rem) m_drops = sat_add(m_drops, 1);
          if (occ_before == 0 && !bus.pifo_valid_out) begin
            m_phase = 1; m_done = 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("enq_ready", bus.enq_ready, f_ready());
      chk("pifo_insert", bus.pifo_insert, f_ins());
      chk("pifo_rank_in", bus.pifo_rank_in, f_ins() ? m_fifo[0].r : '0);
      chk("pifo_meta_in", bus.pifo_meta_in, f_ins() ? m_fifo[0].m : '0);
      chk("pifo_remove", bus.pifo_remove, f_rem());
      chk("deq_valid", bus.deq_valid, m_dv);
      chk("deq_rank", bus.deq_rank, m_dr);
      chk("deq_meta", bus.deq_meta, m_dm);
      chk("occupancy", occupancy, m_occ);
      chk("flush_drops", flush_drops, m_drops);
      chk("flush_done", flush_done, m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic enq_one(input int r, input int m);
    bus.enq_valid = 1'b1; bus.enq_rank = RW'(r); bus.enq_meta = MW'(m);
    @(negedge clk);
    chk("enq_accept", bus.enq_ready, 1);
    tick();
    bus.enq_valid = 1'b0;
  endtask

  task automatic wait_deq_valid();
    for (int i = 0; i < 20 && !bus.deq_valid; i++) tick();
    chk("wait_deq_valid", bus.deq_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, acc, nins, nrem, ndone;
    int got[$];
    int exp_order[4] = '{1, 3, 7, 9};
    int r3[3] = '{7, 3, 9};

    bus.enq_valid = 0; bus.enq_rank = '0; bus.enq_meta = '0;
    bus.deq_ready = 0; bus.pifo_busy = 1; bus.pifo_full = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Busy for 5 cycles after reset: enq_ready first rises in cycle 6.
    first = 99;
    for (int c = 0; c < 10; c++) begin
      bus.pifo_busy = (c < 5);
      @(negedge clk);
      if (bus.enq_ready && first == 99) first = c;
      tick();
    end
    chk("ready_first_cycle", first, 6);

    // Park one entry in the output register so the burst stays in the PIFO.
    enq_one(1, 'h101);
    wait_deq_valid();
    chk("preload_rank", bus.deq_rank, 1);

    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        bus.enq_valid = 1; bus.enq_rank = RW'(r3[c]); bus.enq_meta = MW'('h700 + c);
      end else bus.enq_valid = 0;
      @(negedge clk);
      if (c < 3) chk("burst_accept", bus.enq_ready, 1);
      chk("burst_insert", bus.pifo_insert, (c >= 1 && c <= 3));
      tick();
    end
    chk("occ_after_burst", occupancy, 3);

    bus.deq_ready = 1;
    for (int i = 0; i < 20 && got.size() < 4; i++) begin
      @(negedge clk);
      if (bus.deq_valid && bus.deq_ready) got.push_back(int'(bus.deq_rank));
      tick();
    end
    chk("deq_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("deq_order", (k < got.size()) ? got[k] : -1, exp_order[k]);
    tick();
    chk("occ_after_drain", occupancy, 0);
    bus.deq_ready = 0;

    // Full PIFO: only 4 entries fit in the input FIFO.
    enq_one(50, 'h500);
    wait_deq_valid();
    bus.pifo_full = 1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.enq_valid = 1; bus.enq_rank = RW'(60 + c); bus.enq_meta = MW'('h600 + c);
      @(negedge clk);
      if (bus.enq_ready) acc++;
      tick();
    end
    bus.enq_valid = 0;
    chk("full_accepted", acc, 4);
    @(negedge clk);
    chk("full_enq_ready", bus.enq_ready, 0);
    tick();
    bus.pifo_full = 0;
    nins = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.pifo_insert) nins++;
      tick();
    end
    chk("full_release_inserts", nins, 4);
    chk("occ_after_full", occupancy, 4);
    bus.deq_ready = 1;
    for (int i = 0; i < 20 && (bus.deq_valid || occupancy != 0); i++) tick();
    chk("drain2_occ", occupancy, 0);
    bus.deq_ready = 0;

    // Backpressure: one remove while deq_ready=0, the next only with deq_ready.
    bus.pifo_full = 1;
    enq_one(20, 'h200);
    enq_one(10, 'h100);
    bus.pifo_full = 0;
    nrem = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.pifo_remove) nrem++;
      tick();
    end
    chk("bp_removes", nrem, 1);
    chk("bp_hold_rank", bus.deq_rank, 20);
    chk("bp_occ", occupancy, 1);
    bus.deq_ready = 1;
    @(negedge clk);
    chk("bp_remove_on_ready", bus.pifo_remove, 1);
    tick();
    bus.deq_ready = 0;
    @(negedge clk);
    chk("bp_next_rank", bus.deq_rank, 10);
    tick();

    // Flush with 3 in PIFO, 2 in FIFO and a held output entry.
    enq_one(30, 'h300);
    enq_one(31, 'h301);
    enq_one(32, 'h302);
    repeat (3) tick();
    chk("pre_flush_occ", occupancy, 3);
    bus.pifo_full = 1;
    enq_one(33, 'h303);
    enq_one(34, 'h304);
    flush = 1;
    nrem = 0; ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.pifo_remove) nrem++;
      if (flush_done) ndone++;
      tick();
      flush = 0;
    end
    chk("flush_removes", nrem, 3);
    chk("flush_done_pulses", ndone, 1);
    chk("flush_drops_total", flush_drops, 6);
    chk("flush_occ", occupancy, 0);
    chk("flush_deq_valid", bus.deq_valid, 0);
    bus.pifo_full = 0;

    // Insert and remove in the same cycle leave occupancy at 2.
    for (int c = 0; c < 3; c++) begin
      bus.enq_valid = 1; bus.enq_rank = RW'(40 + c); bus.enq_meta = MW'('h400 + c);
      tick();
    end
    bus.enq_valid = 0;
    repeat (3) tick();
    chk("pre_both_occ", occupancy, 2);
    enq_one(43, 'h403);
    bus.deq_ready = 1;
    @(negedge clk);
    chk("both_insert", bus.pifo_insert, 1);
    chk("both_remove", bus.pifo_remove, 1);
    tick();
    bus.deq_ready = 0;
    @(negedge clk);
    chk("occ_ins_rem_same_cycle", occupancy, 2);
    tick();

    // Reset mid-operation discards everything.
    rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_occ", occupancy, 0);
    chk("rst_deq_valid", bus.deq_valid, 0);
    chk("rst_enq_ready", bus.enq_ready, 0);
    tick();
    @(negedge clk);
    chk("rst_run_ready", bus.enq_ready, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
